product_accumulator: RTL

//  Downstream stage of the 16x16 Multiplier: consumes its 32-bit product, sums a programmed

---
 rtl/product_accumulator_pkg.sv | 18 +
 rtl/product_accumulator_if.sv | 36 +++
 rtl/product_accumulator_acc_sat_adder.sv | 30 +++
 rtl/product_accumulator.sv | 102 ++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// product_accum_pkg: shared definitions for the product accumulator.
//   state_e - FSM encoding (ST_IDLE=0, ST_ACCUM=1, ST_DONE=2)
//   PROD_W  - default incoming product width (matches the 16x16 multiplier result)
//   ACC_W   - default accumulator / result width (must be >= PROD_W)
//   CNT_W   - default term counter width (max terms per run = 2**CNT_W-1)
package product_accum_pkg;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: run control, product input and result handshake of the accumulator.
//   start      - pulse to begin a run (only honoured in idle)
//   num_terms  - products to sum, sampled with start
//   in_valid / in_ready / product   - product stream from the multiplier
//   out_valid / out_ready / acc_out - final sum handshake
//   busy       - run in progress or result pending
//   overflow   - sticky carry out of the accumulator during this run
// Modports: master drives run control, products and out_ready; slave is the accumulator.
interface product_accumulator_if #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 8
);

  logic              start;
  logic [CNT_W-1:0]  num_terms;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              busy;
  logic              overflow;

  modport master (
    output start, num_terms, in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, busy, overflow
  );

  modport slave (
    input  start, num_terms, in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, busy, overflow
  );

endinterface

// File: rtl/product_accumulator_acc_sat_adder.sv
// acc_sat_adder: combinational accumulate step, acc + zero-extended product.
//   i_acc     - current accumulator value (ACC_W)
//   i_product - unsigned product to add (PROD_W, PROD_W <= ACC_W)
//   o_sum     - next accumulator value (ACC_W)
//   o_carry   - carry out of bit ACC_W-1
// Build option SATURATE_ACC_EN: on carry the sum clamps to all ones; otherwise it wraps.
module acc_sat_adder #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_product,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_sum_wide;

  always_comb begin
    w_sum_wide = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_product};
    o_carry    = w_sum_wide[ACC_W];
`ifdef SATURATE_ACC_EN
    // Once clamped, adding zero keeps all ones and anything else carries again.
    o_sum      = w_sum_wide[ACC_W] ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
`else
    o_sum      = w_sum_wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of unsigned products and presents the total
// with a valid/ready handshake (accumulate half of a multiply-accumulate datapath).
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; aborts any run without emitting a result
//   io_bus - product_accumulator_if.slave (start/num_terms, product stream, result handshake,
//            busy, sticky overflow)
// Build option SATURATE_ACC_EN: accumulator clamps to all ones on carry instead of wrapping.
module product_accumulator #(
  parameter int unsigned PROD_W = product_accum_pkg::PROD_W,
  parameter int unsigned ACC_W  = product_accum_pkg::ACC_W,
  parameter int unsigned CNT_W  = product_accum_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  product_accumulator_if.slave        io_bus
);

  import product_accum_pkg::*;

  state_e             r_state, w_state_next;
  logic [ACC_W-1:0]   r_acc, w_acc_next;
  logic [CNT_W-1:0]   r_count, w_count_next;
  logic               r_overflow, w_overflow_next;

  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_in_ready;

  acc_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .i_acc     (r_acc),
    .i_product (io_bus.product),
    .o_sum     (w_sum),
    .o_carry   (w_carry)
  );

  assign w_in_ready = (r_state == ST_ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_acc      <= w_acc_next;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_acc_next      = r_acc;
    w_count_next    = r_count;
    w_overflow_next = r_overflow;
    unique case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_acc_next      = '0;
          w_overflow_next = 1'b0;
          if (io_bus.num_terms != '0) begin
            w_count_next = io_bus.num_terms;
            w_state_next = ST_ACCUM;
          end else begin
            // Empty sum: result of zero is ready immediately.
            w_state_next = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (io_bus.in_valid && w_in_ready) begin
          w_acc_next      = w_sum;
          w_overflow_next = r_overflow | w_carry;
          w_count_next    = r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Returning to idle forces one idle cycle before another start is seen.
        if (io_bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_state == ST_DONE);
  assign io_bus.busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
  assign io_bus.acc_out   = r_acc;
  assign io_bus.overflow  = r_overflow;

endmodule
